// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue gate with register scoreboard, memory-op limit and branch wait/flush FSM.
module issue_ctrl #(
    parameter int MAX_MEM = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [1:0]  dec_insttype,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rfwe,
    output logic        iss_valid,
    input  logic        iss_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        mem_done,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        flush,
    output logic [31:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [2:0]  mem_q, mem_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] wb_mask, set_mask, eff;
    logic        raw_haz, waw_haz, is_ag, is_br, mem_full, can_issue, run, fire;

    always_comb begin
        wb_mask   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
        eff       = pend_q & ~wb_mask;
        raw_haz   = eff[dec_rs] | eff[dec_rt];
        waw_haz   = dec_rfwe & (dec_rd != 5'd0) & eff[dec_rd];
        is_ag     = dec_insttype == 2'b10;
        is_br     = dec_insttype == 2'b01;
        mem_full  = (mem_q == 3'(MAX_MEM)) & ~mem_done;
        can_issue = ~raw_haz & ~waw_haz & ~(is_ag & mem_full);
        run       = rst_n & (state_q == RUN);
        iss_valid = run & dec_valid & can_issue;
        dec_ready = run & iss_ready & can_issue;
        flush     = rst_n & (state_q == FLUSH);
        fire      = dec_valid & dec_ready;
        // Set is applied after the writeback clear so a same-cycle set wins.
        set_mask  = (fire & dec_rfwe & (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;
        pend_d    = eff | set_mask;
        mem_d     = (fire & is_ag) == (mem_done & (mem_q != 3'd0)) ? mem_q :
                    (fire & is_ag) ? mem_q + 3'd1 : mem_q - 3'd1;
        stall_d   = (run & dec_valid & ~can_issue & ~&stall_q) ? stall_q + 32'd1 : stall_q;
        stall_cnt = stall_q;
        state_d   = state_q;
        case (state_q)
            RUN:     state_d = (fire & is_br) ? BR_WAIT : RUN;
            BR_WAIT: state_d = br_resolve ? (br_taken ? FLUSH : RUN) : BR_WAIT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pend_q  <= '0;
            mem_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed checks of hazards, memory limit, branch flow, reset and stall saturation.
module tb_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, dec_valid, dec_rfwe, iss_ready, wb_valid, mem_done, br_resolve, br_taken;
    logic [1:0]  dec_insttype;
    logic [4:0]  dec_rs, dec_rt, dec_rd, wb_rd;
    logic        dec_ready, iss_valid, flush;
    logic [31:0] stall_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [1:0] AL = 2'b00, BR = 2'b01, AG = 2'b10;

    issue_ctrl #(.MAX_MEM(2)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_insttype(dec_insttype), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .dec_rfwe(dec_rfwe), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .mem_done(mem_done),
        .br_resolve(br_resolve), .br_taken(br_taken), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [1:0] t, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic we);
        dec_valid = v; dec_insttype = t; dec_rs = rs; dec_rt = rt; dec_rd = rd; dec_rfwe = we;
        #1;
    endtask

    task automatic io(input string tag, input logic rdy, input logic iv, input logic fl);
        chk({tag, ".rdy"}, 32'(dec_ready), 32'(rdy));
        chk({tag, ".iv"}, 32'(iss_valid), 32'(iv));
        chk({tag, ".fl"}, 32'(flush), 32'(fl));
    endtask

    initial begin
        rst_n = 0; iss_ready = 1; wb_valid = 0; wb_rd = 0; mem_done = 0; br_resolve = 0; br_taken = 0;
        @(negedge clk);
        dec(1, BR, 0, 0, 3, 1);
        io("rst", 0, 0, 0);
        @(negedge clk);
        chk("rst.stall", stall_cnt, 0);
        rst_n = 1;

        // RAW on x5 released by same-cycle writeback
        dec(1, AL, 1, 2, 5, 1);
        io("raw.first", 1, 1, 0);
        @(negedge clk);
        dec(1, AL, 5, 0, 6, 1);
        io("raw.stall", 0, 0, 0);
        @(negedge clk);
        chk("raw.st1", stall_cnt, 1);
        @(negedge clk);
        chk("raw.st2", stall_cnt, 2);
        wb_valid = 1; wb_rd = 5; #1;
        io("raw.wb", 1, 1, 0);
        @(negedge clk);
        wb_valid = 0;
        chk("raw.st_hold", stall_cnt, 2);

        // backpressure is not a stall
        iss_ready = 0;
        dec(1, AL, 1, 0, 0, 0);
        io("bp", 0, 1, 0);
        @(negedge clk);
        chk("bp.st", stall_cnt, 2);
        iss_ready = 1;

        // WAW on x6, then set-wins when writeback and re-issue hit x6 together
        dec(1, AL, 0, 0, 6, 1);
        io("waw", 0, 0, 0);
        @(negedge clk);
        wb_valid = 1; wb_rd = 6; #1;
        io("waw.wb", 1, 1, 0);
        @(negedge clk);
        wb_valid = 0;
        dec(1, AL, 6, 0, 0, 0);
        io("setwins", 0, 0, 0);
        @(negedge clk);
        chk("waw.st", stall_cnt, 4);
        wb_valid = 1; wb_rd = 6; #1;
        @(negedge clk);
        wb_valid = 0;

        // memory limit with MAX_MEM=2
        dec(1, AG, 0, 0, 0, 0);
        io("ld1", 1, 1, 0);
        @(negedge clk);
        io("ld2", 1, 1, 0);
        @(negedge clk);
        io("ld3.full", 0, 0, 0);
        dec(1, AL, 0, 0, 0, 0);
        chk("al.notblocked", 32'(dec_ready), 1);
        dec(1, AG, 0, 0, 0, 0);
        @(negedge clk);
        chk("ld.st", stall_cnt, 5);
        chk("ld.cnt2", 32'(dut.mem_q), 2);
        mem_done = 1; #1;
        io("ld3.done", 1, 1, 0);
        @(negedge clk);
        chk("ld.cnt_stay", 32'(dut.mem_q), 2);
        dec(0, AL, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mem.zero_hold", 32'(dut.mem_q), 0);
        mem_done = 0;

        // taken branch
        dec(1, BR, 0, 0, 0, 0);
        io("beq", 1, 1, 0);
        @(negedge clk);
        dec(1, AL, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            io("brwait", 0, 0, 0);
            @(negedge clk);
        end
        br_resolve = 1; br_taken = 1; #1;
        io("resolve", 0, 0, 0);
        @(negedge clk);
        br_resolve = 0; br_taken = 0; #1;
        io("flush", 0, 0, 1);
        @(negedge clk);
        io("resume", 1, 1, 0);
        chk("br.st", stall_cnt, 5);

        // not-taken branch
        dec(1, BR, 0, 0, 0, 0);
        @(negedge clk);
        dec(1, AL, 0, 0, 0, 0);
        br_resolve = 1; #1;
        @(negedge clk);
        br_resolve = 0; #1;
        io("nt.run", 1, 1, 0);

        // resolve in RUN ignored
        dec(0, AL, 0, 0, 0, 0);
        br_resolve = 1; br_taken = 1; #1;
        @(negedge clk);
        br_resolve = 0; br_taken = 0; #1;
        chk("runresolve.fl", 32'(flush), 0);

        // rd=0 never pends
        dec(1, AL, 0, 0, 0, 1);
        @(negedge clk);
        dec(1, AL, 0, 0, 0, 1);
        io("x0", 1, 1, 0);
        chk("x0.pend", dut.pend_q, 0);
        @(negedge clk);

        // reset in BR_WAIT with x7 pending
        dec(1, AL, 0, 0, 7, 1);
        @(negedge clk);
        dec(1, BR, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 0;
        dec(1, AL, 7, 0, 0, 0);
        io("midrst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1; #1;
        io("postrst", 1, 1, 0);
        chk("postrst.st", stall_cnt, 0);
        @(negedge clk);

        // saturation
        dec(1, AL, 0, 0, 9, 1);
        @(negedge clk);
        dec(1, AL, 9, 0, 0, 0);
        dut.stall_q = 32'hFFFF_FFFE;
        #1;
        chk("sat.pre", stall_cnt, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("sat.max", stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sat.hold", stall_cnt, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
